// File: rtl/calc_disp_pkg.sv
// Shared types and seven-segment constants for the binary-to-decimal display path.
// Segment codes are active-low, bit6=g .. bit0=a.
package calc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_DIGIT = 2'd0,
        SEL_BLANK = 2'd1,
        SEL_MINUS = 2'd2,
        SEL_ERR   = 2'd3
    } seg_sel_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Enough BCD nibbles to hold any WIDTH-bit magnitude.
    function automatic int nbcd(input int width);
        return width / 3 + 2;
    endfunction

endpackage

// File: rtl/calc_seg7_encode.sv
// One display digit: 4-bit value plus blank/minus/error select to an active-low
// seven-segment code.
module calc_seg7_encode
    import calc_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  seg_sel_t   sel,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (sel)
            SEL_MINUS: seg = SEG_MINUS;
            SEL_ERR:   seg = SEG_E;
            SEL_DIGIT: begin
                case (digit)
                    4'h0:    seg = SEG_0;
                    4'h1:    seg = SEG_1;
                    4'h2:    seg = SEG_2;
                    4'h3:    seg = SEG_3;
                    4'h4:    seg = SEG_4;
                    4'h5:    seg = SEG_5;
                    4'h6:    seg = SEG_6;
                    4'h7:    seg = SEG_7;
                    4'h8:    seg = SEG_8;
                    4'h9:    seg = SEG_9;
                    4'hA:    seg = SEG_A;
                    4'hB:    seg = SEG_B;
                    4'hC:    seg = SEG_C;
                    4'hD:    seg = SEG_D;
                    4'hE:    seg = SEG_E;
                    default: seg = SEG_F;
                endcase
            end
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_bin2seg_disp.sv
// Sequential double-dabble binary-to-decimal converter driving DIGITS seven-segment
// displays. Define CALC_DISP_HEX_MODE_EN to add the iHEX raw-hex display mode.
module calc_bin2seg_disp
    import calc_disp_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6,
    parameter int SIGNED = 1
) (
    input  logic                  iCLK_50,
    input  logic                  iRST,
    input  logic                  iSTART,
`ifdef CALC_DISP_HEX_MODE_EN
    input  logic                  iHEX,
`endif
    input  logic [WIDTH-1:0]      iVALUE,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic                  oOVF,
    output logic [7*DIGITS-1:0]   oSEG
);

    localparam int NBCD = nbcd(WIDTH);
    localparam int CW   = $clog2(WIDTH);
    localparam int HW   = 4 * DIGITS;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      mag_q, mag_d;
    logic                  neg_q, neg_d;
    logic [4*NBCD-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  sign_in;
    logic [WIDTH-1:0]      mag_in;
    logic [4*NBCD-1:0]     bcd_adj;
    logic [4*NBCD-1:0]     bcd_shift;
    logic [3:0]            nib [NBCD];
    int                    sig_cnt;
    logic                  dec_ovf;
    logic                  fmt_ovf;
    logic [7*DIGITS-1:0]   seg_fmt;

    // The negated value fits in WIDTH bits: the largest magnitude is 2^(WIDTH-1).
    assign sign_in = (SIGNED != 0) && iVALUE[WIDTH-1];
    assign mag_in  = sign_in ? (~iVALUE + WIDTH'(1)) : iVALUE;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NBCD; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[4*NBCD-2:0], mag_q[WIDTH-1]};
    end

    for (genvar gi = 0; gi < NBCD; gi++) begin : g_nib
        assign nib[gi] = bcd_q[4*gi +: 4];
    end

    always_comb begin
        sig_cnt = 1;
        for (int i = 0; i < NBCD; i++) begin
            if (nib[i] != 4'd0) sig_cnt = i + 1;
        end
        dec_ovf = 1'b0;
        for (int i = DIGITS; i < NBCD; i++) begin
            if (nib[i] != 4'd0) dec_ovf = 1'b1;
        end
        if (neg_q && (sig_cnt == DIGITS)) dec_ovf = 1'b1;
    end

`ifdef CALC_DISP_HEX_MODE_EN
    logic            hex_q, hex_d;
    logic [HW-1:0]   hex_val;
    logic            hex_ovf;

    if (WIDTH > HW) begin : g_hex_trunc
        assign hex_val = mag_q[HW-1:0];
        assign hex_ovf = |mag_q[WIDTH-1:HW];
    end else begin : g_hex_ext
        assign hex_val = HW'(mag_q);
        assign hex_ovf = 1'b0;
    end

    assign fmt_ovf = hex_q ? hex_ovf : dec_ovf;
`else
    assign fmt_ovf = dec_ovf;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] dec_nib;
        logic [3:0] val;
        seg_sel_t   sel;

        if (gi < NBCD) begin : g_has_nib
            assign dec_nib = nib[gi];
        end else begin : g_no_nib
            assign dec_nib = 4'd0;
        end

        always_comb begin
            val = dec_nib;
            sel = SEL_BLANK;
            if (dec_ovf) begin
                sel = (gi == 0) ? SEL_ERR : SEL_BLANK;
            end else if (gi < sig_cnt) begin
                sel = SEL_DIGIT;
            end else if (neg_q && (gi == sig_cnt)) begin
                sel = SEL_MINUS;
            end
`ifdef CALC_DISP_HEX_MODE_EN
            if (hex_q) begin
                val = hex_val[4*gi +: 4];
                sel = SEL_DIGIT;
            end
`endif
        end

        calc_seg7_encode u_enc (
            .digit (val),
            .sel   (sel),
            .seg   (seg_fmt[7*gi +: 7])
        );
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef CALC_DISP_HEX_MODE_EN
        hex_d   = hex_q;
`endif
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    mag_d   = mag_in;
                    neg_d   = sign_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
`ifdef CALC_DISP_HEX_MODE_EN
                    hex_d   = iHEX;
                    if (iHEX) begin
                        mag_d   = iVALUE;
                        neg_d   = 1'b0;
                        state_d = LOAD;
                    end
`endif
                end
            end
            CONV: begin
                bcd_d = bcd_shift;
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = LOAD;
            end
            LOAD: begin
                seg_d   = seg_fmt;
                ovf_d   = fmt_ovf;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK_50 or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= '1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CALC_DISP_HEX_MODE_EN
            hex_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef CALC_DISP_HEX_MODE_EN
            hex_q   <= hex_d;
`endif
        end
    end

    assign oBUSY = busy_q;
    assign oDONE = done_q;
    assign oOVF  = ovf_q;
    assign oSEG  = seg_q;

endmodule

// File: tb/tb_calc_bin2seg_disp.sv
// Self-checking bench for calc_bin2seg_disp (WIDTH=20, DIGITS=6, SIGNED=1) against a
// decimal-arithmetic display model.
module tb_calc_bin2seg_disp;

    localparam int WIDTH  = 20;
    localparam int DIGITS = 6;
    localparam int LAT    = WIDTH + 1;

    logic                 iCLK_50 = 1'b0;
    logic                 iRST    = 1'b1;
    logic                 iSTART  = 1'b0;
    logic [WIDTH-1:0]     iVALUE  = '0;
`ifdef CALC_DISP_HEX_MODE_EN
    logic                 iHEX    = 1'b0;
`endif
    logic                 oBUSY;
    logic                 oDONE;
    logic                 oOVF;
    logic [7*DIGITS-1:0]  oSEG;

    int checks   = 0;
    int failures = 0;

    calc_bin2seg_disp #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(1)) dut (
        .iCLK_50 (iCLK_50),
        .iRST    (iRST),
        .iSTART  (iSTART),
`ifdef CALC_DISP_HEX_MODE_EN
        .iHEX    (iHEX),
`endif
        .iVALUE  (iVALUE),
        .oBUSY   (oBUSY),
        .oDONE   (oDONE),
        .oOVF    (oOVF),
        .oSEG    (oSEG)
    );

    always #10 iCLK_50 = ~iCLK_50;

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected display: decimal digits of |v|, minus sign to the left, 'E' on overflow.
    function automatic logic [7*DIGITS-1:0] model_seg(input int v, output logic ovf);
        logic [7*DIGITS-1:0] s;
        longint mag;
        longint t;
        int nd;
        bit neg;
        s   = '1;
        neg = (v < 0);
        mag = neg ? -longint'(v) : longint'(v);
        nd  = 1;
        t   = mag / 10;
        while (t != 0) begin
            nd++;
            t = t / 10;
        end
        ovf = (nd > DIGITS) || (neg && nd == DIGITS);
        if (ovf) begin
            s[6:0] = 7'b0000110;
        end else begin
            t = mag;
            for (int i = 0; i < nd; i++) begin
                s[7*i +: 7] = seg_code(int'(t % 10));
                t = t / 10;
            end
            if (neg) s[7*nd +: 7] = 7'b0111111;
        end
        return s;
    endfunction

    // Drives one start and waits (bounded) for oDONE; reports the done edge and
    // handshake anomalies (busy wrong on some edge, or done still high at the start edge).
    task automatic do_conv(input int v, output int edges, output int hs_bad);
        edges  = -1;
        hs_bad = 0;
        @(negedge iCLK_50);
        iVALUE = WIDTH'(v);
        iSTART = 1'b1;
        @(posedge iCLK_50);
        #1;
        if (oBUSY !== 1'b1) hs_bad++;
        if (oDONE !== 1'b0) hs_bad++;
        @(negedge iCLK_50);
        iSTART = 1'b0;
        iVALUE = WIDTH'($urandom);
        for (int n = 1; n <= 3 * LAT && edges < 0; n++) begin
            @(posedge iCLK_50);
            #1;
            if (oDONE === 1'b1) edges = n;
            if ((n <= WIDTH) != (oBUSY === 1'b1)) hs_bad++;
        end
    endtask

    task automatic check_conv(input string name, input int v);
        int edges;
        int hs_bad;
        logic exp_ovf;
        logic [7*DIGITS-1:0] exp_seg;
        do_conv(v, edges, hs_bad);
        exp_seg = model_seg(v, exp_ovf);
        checks++;
        if (edges !== LAT) begin
            failures++;
            $display("FAIL %s latency value=%0d got=%0d expected=%0d", name, v, edges, LAT);
        end
        checks++;
        if (hs_bad !== 0) begin
            failures++;
            $display("FAIL %s handshake value=%0d bad_edges=%0d expected=0", name, v, hs_bad);
        end
        checks++;
        if (oSEG !== exp_seg || oOVF !== exp_ovf) begin
            failures++;
            $display("FAIL %s display value=%0d seg=%h ovf=%b expected seg=%h ovf=%b",
                     name, v, oSEG, oOVF, exp_seg, exp_ovf);
        end
        $display("conv %s value=%0d seg=%h ovf=%b latency=%0d", name, v, oSEG, oOVF, edges);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge iCLK_50);
        @(negedge iCLK_50);
        checks++;
        if (oSEG !== '1 || oBUSY !== 1'b0 || oDONE !== 1'b0 || oOVF !== 1'b0) begin
            failures++;
            $display("FAIL reset_in seg=%h busy=%b done=%b ovf=%b expected seg=all-ones 0 0 0",
                     oSEG, oBUSY, oDONE, oOVF);
        end
        iRST = 1'b0;
        repeat (2) @(negedge iCLK_50);
        checks++;
        if (oSEG !== '1 || oBUSY !== 1'b0 || oDONE !== 1'b0 || oOVF !== 1'b0) begin
            failures++;
            $display("FAIL reset_after seg=%h busy=%b done=%b ovf=%b expected seg=all-ones 0 0 0",
                     oSEG, oBUSY, oDONE, oOVF);
        end
        $display("reset seg=%h busy=%b done=%b ovf=%b", oSEG, oBUSY, oDONE, oOVF);
    endtask

    task automatic test_boundaries();
        int vals [10] = '{12345, 0, -42, 524287, -524288, -99999, -100000, 99999, 100000, -9};
        for (int i = 0; i < 10; i++) check_conv("boundary", vals[i]);
    endtask

    task automatic test_hold();
        logic exp_ovf;
        logic [7*DIGITS-1:0] exp_seg;
        check_conv("hold_load", -4321);
        exp_seg = model_seg(-4321, exp_ovf);
        iVALUE = WIDTH'(777);
        repeat (5) @(negedge iCLK_50);
        checks++;
        if (oSEG !== exp_seg || oOVF !== exp_ovf || oDONE !== 1'b0) begin
            failures++;
            $display("FAIL hold seg=%h ovf=%b done=%b expected seg=%h ovf=%b done=0",
                     oSEG, oOVF, oDONE, exp_seg, exp_ovf);
        end
        $display("hold seg=%h ovf=%b", oSEG, oOVF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int v;
            v = int'($urandom_range(0, (1 << WIDTH) - 1));
            if (v >= (1 << (WIDTH - 1))) v = v - (1 << WIDTH);
            if (i % 3 == 0) v = v % 1000;
            check_conv("random", v);
        end
    endtask

    task automatic test_back_to_back();
        check_conv("b2b_first", 65535);
        check_conv("b2b_second", -300000);
        check_conv("b2b_third", 8);
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int done_edge = -1;
        logic exp_ovf;
        logic [7*DIGITS-1:0] exp_seg;
        exp_seg = model_seg(7, exp_ovf);
        @(negedge iCLK_50);
        iVALUE = WIDTH'(7);
        iSTART = 1'b1;
        @(posedge iCLK_50);
        for (int n = 1; n <= 30; n++) begin
            @(negedge iCLK_50);
            iSTART = (n == 5 || n == 21);
            iVALUE = WIDTH'($urandom);
            @(posedge iCLK_50);
            #1;
            if (oDONE === 1'b1) begin
                dones++;
                done_edge = n;
            end
        end
        @(negedge iCLK_50);
        iSTART = 1'b0;
        checks++;
        if (dones !== 1 || done_edge !== LAT) begin
            failures++;
            $display("FAIL start_ignored done_count=%0d done_edge=%0d expected 1 at %0d",
                     dones, done_edge, LAT);
        end
        checks++;
        if (oSEG !== exp_seg || oOVF !== exp_ovf || oBUSY !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored_display seg=%h ovf=%b busy=%b expected seg=%h ovf=%b busy=0",
                     oSEG, oOVF, oBUSY, exp_seg, exp_ovf);
        end
        $display("start_ignored dones=%0d edge=%0d seg=%h", dones, done_edge, oSEG);
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        check_conv("pre_reset_ovf", -100000);
        @(negedge iCLK_50);
        iVALUE = WIDTH'(123456);
        iSTART = 1'b1;
        @(posedge iCLK_50);
        @(negedge iCLK_50);
        iSTART = 1'b0;
        repeat (8) @(posedge iCLK_50);
        @(negedge iCLK_50);
        iRST = 1'b1;
        #1;
        checks++;
        if (oSEG !== '1 || oBUSY !== 1'b0 || oDONE !== 1'b0 || oOVF !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid seg=%h busy=%b done=%b ovf=%b expected seg=all-ones 0 0 0",
                     oSEG, oBUSY, oDONE, oOVF);
        end
        repeat (2) @(negedge iCLK_50);
        iRST = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge iCLK_50);
            #1;
            if (oDONE === 1'b1 || oBUSY === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || oSEG !== '1) begin
            failures++;
            $display("FAIL reset_mid_abort done_or_busy_edges=%0d seg=%h expected 0 and all-ones",
                     dones, oSEG);
        end
        $display("reset_mid seg=%h busy=%b ovf=%b", oSEG, oBUSY, oOVF);
        check_conv("post_reset", -777);
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_hold();
        test_random();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
